// File: rtl/vga_sram_responder.sv
// VGA-side request responder for a pipelined ZBT SRAM: issues one command per cycle,
// drives write data two cycles after the command and queues read data in request order.
module vga_sram_responder #(
    parameter int RESP_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [50:0] req_put,
    input  logic        EN_req_put,
    output logic        RDY_req_put,
    output logic [31:0] resp_get,
    input  logic        EN_resp_get,
    output logic        RDY_resp_get,
    output logic [17:0] sram_address_out,
    output logic [31:0] sram_data_O,
    input  logic [31:0] sram_data_I,
    output logic        sram_data_T,
    output logic [3:0]  sram_we_bytes_out,
    output logic        sram_we_out,
    output logic        sram_ce_out,
    output logic        sram_oe_out,
    output logic        sram_cen_out,
    output logic        sram_adv_ld_out,
    output logic [4:0]  outstanding
);

    localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [4:0] DEPTH_LIMIT = 5'(RESP_DEPTH);

    typedef struct packed {
        logic        valid;
        logic        write;
        logic [31:0] data;
    } stage_t;

    // Request fields
    logic        req_write;
    logic [17:0] req_addr;
    logic [31:0] req_data;

    assign req_write = req_put[50];
    assign req_addr  = req_put[49:32];
    assign req_data  = req_put[31:0];

    // Command tracking: stage_a is the cycle the command is on the pins, stage_b
    // the cycle after; capture_c marks a read whose data is on the bus now.
    stage_t stage_a;
    stage_t stage_b;
    logic   capture_c;
    logic   running;

    logic accept;
    logic push;
    logic pop;

    logic [31:0]      fifo_mem [RESP_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] fifo_count_next;
    logic [4:0]       reads_in_flight;

    assign accept = EN_req_put && RDY_req_put;
    assign pop    = EN_resp_get && RDY_resp_get;
    assign push   = capture_c;

    // Reads are counted from issue, so the FIFO always has room when their data lands.
    assign reads_in_flight = 5'(stage_a.valid && !stage_a.write)
                           + 5'(stage_b.valid && !stage_b.write)
                           + 5'(capture_c);
    assign outstanding  = reads_in_flight + 5'(fifo_count);
    assign RDY_req_put  = running && (outstanding < DEPTH_LIMIT);
    assign RDY_resp_get = (fifo_count != '0);
    assign resp_get     = fifo_mem[rd_ptr];

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            running           <= 1'b0;
            stage_a           <= '0;
            stage_b           <= '0;
            capture_c         <= 1'b0;
            sram_address_out  <= '0;
            sram_ce_out       <= 1'b1;
            sram_we_out       <= 1'b1;
            sram_we_bytes_out <= 4'hF;
            sram_adv_ld_out   <= 1'b0;
            sram_oe_out       <= 1'b0;
            sram_cen_out      <= 1'b0;
            sram_data_O       <= '0;
            sram_data_T       <= 1'b1;
        end else begin
            running   <= 1'b1;
            stage_a   <= '{valid: accept, write: req_write, data: req_data};
            stage_b   <= stage_a;
            capture_c <= stage_b.valid && !stage_b.write;

            sram_adv_ld_out <= 1'b0;
            sram_oe_out     <= 1'b0;
            sram_cen_out    <= 1'b0;
            if (accept) begin
                sram_address_out  <= req_addr;
                sram_ce_out       <= 1'b0;
                sram_we_out       <= !req_write;
                sram_we_bytes_out <= req_write ? 4'h0 : 4'hF;
            end else begin
                sram_ce_out       <= 1'b1;
                sram_we_out       <= 1'b1;
                sram_we_bytes_out <= 4'hF;
            end

            // Write data goes out two cycles after its command (ZBT late-write).
            sram_data_T <= !(stage_b.valid && stage_b.write);
            if (stage_b.valid && stage_b.write) begin
                sram_data_O <= stage_b.data;
            end
        end
    end

    // NOTE: always_comb assigns a default first so no path leaves the value held (no latch).
    always_comb begin
        fifo_count_next = fifo_count;
        case ({push, pop})
            2'b10:   fifo_count_next = fifo_count + CNT_W'(1);
            2'b01:   fifo_count_next = fifo_count - CNT_W'(1);
            default: fifo_count_next = fifo_count;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            fifo_count <= fifo_count_next;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // NOTE: storage is not reset; an entry is only observed once fifo_count covers it.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr] <= sram_data_I;
        end
    end

endmodule

// File: doc/vga_sram_responder.md
VGA_SRAM_RESPONDER -- requirements
Module: vga_sram_responder

Interface
REQ-001 SHALL have parameter RESP_DEPTH, default 4: response FIFO depth in 32-bit words (power of 2, 2..16).
REQ-002 SHALL have port CLK  in  1  sole clock; all state on its rising edge.
REQ-003 SHALL have port RST_N  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_put  in  51  VGA request: [50]=write, [49:32]=word address, [31:0]=write data.
REQ-005 SHALL have port EN_req_put  in  1  request accepted this cycle; legal only when RDY_req_put=1.
REQ-006 SHALL have port RDY_req_put  out  1  responder can accept a request.
REQ-007 SHALL have port resp_get  out  32  head of the response FIFO (read data).
REQ-008 SHALL have port EN_resp_get  in  1  pop the response FIFO; legal only when RDY_resp_get=1.
REQ-009 SHALL have port RDY_resp_get  out  1  response FIFO not empty.
REQ-010 SHALL have port sram_address_out  out  18  ZBT address.
REQ-011 SHALL have port sram_data_O  out  32  ZBT write data.
REQ-012 SHALL have port sram_data_I  in  32  ZBT read data, sampled every cycle.
REQ-013 SHALL have port sram_data_T  out  1  tristate control; 1 = pad is input.
REQ-014 SHALL have ports sram_we_bytes_out (4), sram_we_out, sram_ce_out, sram_oe_out, sram_cen_out, sram_adv_ld_out  out  ZBT controls, all active-low.
REQ-015 SHALL have port outstanding  out  5  reads in flight plus FIFO occupancy.

Function
REQ-016 All SRAM outputs SHALL be registered; an accept in cycle t SHALL drive its command in cycle A=t+1.
REQ-017 Idle cycle SHALL drive ce=1, we=1, we_bytes=4'hF, adv_ld=0, oe=0, cen=0, data_T=1, and hold the previous address.
REQ-018 Read command SHALL drive ce=0, we=1, adv_ld=0, address=req[49:32].
REQ-019 Write command SHALL drive ce=0, we=0, we_bytes=4'h0, adv_ld=0, address=req[49:32].
REQ-020 Write data SHALL be driven on sram_data_O with data_T=0 in cycle A+2 only; data_T SHALL be 1 in every other cycle.
REQ-021 Read data SHALL be captured from sram_data_I at the end of cycle A+2 and pushed into the FIFO, so RDY_resp_get rises in A+3, four cycles after accept.
REQ-022 A 2-stage valid/kind/data shift register SHALL track each command from A to A+2; back-to-back requests SHALL issue one per cycle with no bubbles, including read-write-read.
REQ-023 outstanding SHALL equal the read entries in stages A..A+2 plus the FIFO count; writes SHALL never count.
REQ-024 RDY_req_put SHALL equal (outstanding < RESP_DEPTH) for all requests, and SHALL be computed from registers only.
REQ-025 FIFO overflow SHALL be impossible by construction.
REQ-026 Simultaneous push and pop SHALL leave the count unchanged; a pop of the last entry in the same cycle as a push SHALL not glitch RDY_resp_get low.
REQ-027 Responses SHALL leave in request order; writes SHALL produce no response.
REQ-028 EN_req_put asserted while RDY_req_put=0, or EN_resp_get asserted while RDY_resp_get=0, SHALL be ignored.

Reset
REQ-029 On RST_N=0 SHALL immediately force the idle SRAM levels of REQ-017, with address=0, data_O=0, FIFO empty, pipeline invalid, outstanding=0, RDY_resp_get=0.
REQ-030 RDY_req_put SHALL be 0 while RST_N=0 and SHALL be 1 from the first cycle after deassertion.
REQ-031 Reset mid-operation SHALL discard in-flight reads and FIFO contents; no stale response SHALL appear after reset.

Verification
REQ-032 Write (addr 0x00010, data 0xDEADBEEF) accepted at t -> we=0 at t+1; data_O=0xDEADBEEF with data_T=0 at t+3; no response produced.
REQ-033 Read of 0x00010 accepted at t, SRAM model returns 0xDEADBEEF -> RDY_resp_get=1 and resp_get=0xDEADBEEF at t+4.
REQ-034 Five back-to-back reads with EN_resp_get=0 and RESP_DEPTH=4 -> four accepted, RDY_req_put=0 once outstanding=4; after one pop, RDY_req_put returns to 1.
REQ-035 Interleaved W,R,W,R on consecutive cycles -> data_T low exactly in the write A+2 cycles; both reads return the correct data in order.
REQ-036 FIFO holds 1 entry, push and pop in the same cycle -> count stays 1 and RDY_resp_get stays 1.
REQ-037 RST_N asserted low with 2 reads in flight -> outputs idle at once; after release, outstanding=0 and no response appears.
